multicycle_control: RTL and testbench

Main control FSM for the multicycle 16-bit datapath. It sits directly upstream of the ALU control unit. It decodes the 4-bit instruction opcode into per-cycle datapath strobes and drives the 2-bit ALU-op class `aoi`, which the ALU control unit combines with the instruction function code to select the ALU operation. It also sequences instruction and data memory accesses through a req/ready handshake.

---
 rtl/multicycle_control_if.sv | 49 ++++
 rtl/multicycle_control.sv | 176 +++++++++++++++++
 tb/tb_multicycle_control.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// ============================================================================
// Module : multicycle_control_if
// Brief  : Handshake, decode and datapath-strobe bundle between the
//          multicycle control FSM and its datapath/memory environment.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface multicycle_control_if;
    // Stimulus into the controller
    logic       start;
    logic [3:0] opcode;
    logic       zero;
    logic       mem_ready;
    // Strobes out of the controller
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] aoi;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       halted;
    logic       illegal;

    // Controller side
    modport master (
        input  start, opcode, zero, mem_ready,
        output mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond,
               pc_src, alu_src_a, alu_src_b, aoi, reg_write, reg_dst,
               mem_to_reg, halted, illegal
    );

    // Datapath / memory side
    modport slave (
        output start, opcode, zero, mem_ready,
        input  mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond,
               pc_src, alu_src_a, alu_src_b, aoi, reg_write, reg_dst,
               mem_to_reg, halted, illegal
    );
endinterface

`default_nettype wire

// File: rtl/multicycle_control.sv
// ============================================================================
// Module : multicycle_control
// Brief  : Main control FSM of the multicycle 16-bit datapath. Decodes the
//          opcode into per-cycle datapath strobes, drives the ALU-op class
//          (aoi) and sequences memory accesses over a req/ready handshake.
// Config : MULTICYCLE_CTRL_ILLEGAL_TRAP_EN - when defined, an illegal opcode
//          enters an absorbing TRAP state with a sticky 'illegal' flag;
//          otherwise it retires as a 2-cycle NOP.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_control (
    input  wire                     clk,
    input  wire                     rst_n,
    multicycle_control_if.master    bus
);

    localparam logic [3:0] C_OP_R    = 4'b0000;
    localparam logic [3:0] C_OP_LW   = 4'b0001;
    localparam logic [3:0] C_OP_SW   = 4'b0010;
    localparam logic [3:0] C_OP_BEQ  = 4'b0011;
    localparam logic [3:0] C_OP_ADDI = 4'b0100;
    localparam logic [3:0] C_OP_J    = 4'b0101;
    localparam logic [3:0] C_OP_HALT = 4'b1111;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_MEM_WB    = 4'd6,
        S_R_EXEC    = 4'd7,
        S_R_WB      = 4'd8,
        S_IMM_EXEC  = 4'd9,
        S_IMM_WB    = 4'd10,
        S_BRANCH    = 4'd11,
        S_JUMP      = 4'd12,
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
        S_HALT      = 4'd13,
        S_TRAP      = 4'd14
`else
        S_HALT      = 4'd13
`endif
    } state_t;

    state_t state_q;
    state_t state_d;

    // State register; reset forces IDLE at once, abandoning any access
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; mem_ready only matters in the request states
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (bus.start) state_d = S_FETCH;
            S_FETCH:     if (bus.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    C_OP_R:    state_d = S_R_EXEC;
                    C_OP_LW,
                    C_OP_SW:   state_d = S_MEM_ADDR;
                    C_OP_BEQ:  state_d = S_BRANCH;
                    C_OP_ADDI: state_d = S_IMM_EXEC;
                    C_OP_J:    state_d = S_JUMP;
                    C_OP_HALT: state_d = S_HALT;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
                    default:   state_d = S_TRAP;
`else
                    default:   state_d = S_FETCH;
`endif
                endcase
            end
            // Only LW and SW reach MEM_ADDR, so anything not LW is a store
            S_MEM_ADDR:  state_d = (bus.opcode == C_OP_LW) ? S_MEM_READ
                                                           : S_MEM_WRITE;
            S_MEM_READ:  if (bus.mem_ready) state_d = S_MEM_WB;
            S_MEM_WRITE: if (bus.mem_ready) state_d = S_FETCH;
            S_MEM_WB:    state_d = S_FETCH;
            S_R_EXEC:    state_d = S_R_WB;
            S_R_WB:      state_d = S_FETCH;
            S_IMM_EXEC:  state_d = S_IMM_WB;
            S_IMM_WB:    state_d = S_FETCH;
            S_BRANCH:    state_d = S_FETCH;
            S_JUMP:      state_d = S_FETCH;
            S_HALT:      state_d = S_HALT;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
            S_TRAP:      state_d = S_TRAP;
`endif
            default:     state_d = S_IDLE;
        endcase
    end

    // Moore output decode; ir_write/pc_write in FETCH follow mem_ready
    always_comb begin
        bus.mem_req       = 1'b0;
        bus.mem_we        = 1'b0;
        bus.iord          = 1'b0;
        bus.ir_write      = 1'b0;
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.pc_src        = 2'b00;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = 2'b00;
        bus.aoi           = 2'b00;
        bus.reg_write     = 1'b0;
        bus.reg_dst       = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.halted        = 1'b0;
        bus.illegal       = 1'b0;
        case (state_q)
            S_FETCH: begin
                bus.mem_req   = 1'b1;
                bus.alu_src_b = 2'b01;
                bus.ir_write  = bus.mem_ready;
                bus.pc_write  = bus.mem_ready;
            end
            // Speculative branch-target computation
            S_DECODE:    bus.alu_src_b = 2'b11;
            S_MEM_ADDR,
            S_IMM_EXEC: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
            end
            S_MEM_READ: begin
                bus.mem_req = 1'b1;
                bus.iord    = 1'b1;
            end
            S_MEM_WRITE: begin
                bus.mem_req = 1'b1;
                bus.mem_we  = 1'b1;
                bus.iord    = 1'b1;
            end
            S_MEM_WB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
            end
            S_R_EXEC: begin
                bus.alu_src_a = 1'b1;
                bus.aoi       = 2'b10;
            end
            S_R_WB: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = 1'b1;
            end
            S_IMM_WB:    bus.reg_write = 1'b1;
            S_BRANCH: begin
                bus.alu_src_a     = 1'b1;
                bus.aoi           = 2'b01;
                bus.pc_write_cond = 1'b1;
                bus.pc_src        = 2'b01;
            end
            S_JUMP: begin
                bus.pc_write = 1'b1;
                bus.pc_src   = 2'b10;
            end
            S_HALT:      bus.halted = 1'b1;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
            S_TRAP:      bus.illegal = 1'b1;
`endif
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
// ============================================================================
// Module : tb_multicycle_control
// Brief  : Directed self-checking bench for multicycle_control. Expected
//          strobe vectors are queued as each cycle is driven and compared
//          when the DUT presents that cycle's outputs.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_control;

    logic clk;
    logic rst_n;

    multicycle_control_if bus ();

    multicycle_control u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed strobe vector:
    // req we iord irw pcw pcc psrc[2] asa asb[2] aoi[2] rw rd m2r halt ill
    function automatic logic [17:0] mk(
        input logic req, input logic we, input logic io, input logic irw,
        input logic pcw, input logic pcc, input logic [1:0] psrc,
        input logic asa, input logic [1:0] asb, input logic [1:0] ao,
        input logic rw, input logic rd, input logic m2r,
        input logic hlt, input logic ill);
        return {req, we, io, irw, pcw, pcc, psrc, asa, asb, ao,
                rw, rd, m2r, hlt, ill};
    endfunction

    localparam logic [17:0] E_IDLE    = 18'd0;
    localparam logic [17:0] E_FETCH_W = mk(1,0,0,0,0,0,2'b00,0,2'b01,2'b00,0,0,0,0,0);
    localparam logic [17:0] E_FETCH_R = mk(1,0,0,1,1,0,2'b00,0,2'b01,2'b00,0,0,0,0,0);
    localparam logic [17:0] E_DECODE  = mk(0,0,0,0,0,0,2'b00,0,2'b11,2'b00,0,0,0,0,0);
    localparam logic [17:0] E_ADDR    = mk(0,0,0,0,0,0,2'b00,1,2'b10,2'b00,0,0,0,0,0);
    localparam logic [17:0] E_MREAD   = mk(1,0,1,0,0,0,2'b00,0,2'b00,2'b00,0,0,0,0,0);
    localparam logic [17:0] E_MWRITE  = mk(1,1,1,0,0,0,2'b00,0,2'b00,2'b00,0,0,0,0,0);
    localparam logic [17:0] E_MWB     = mk(0,0,0,0,0,0,2'b00,0,2'b00,2'b00,1,0,1,0,0);
    localparam logic [17:0] E_REXEC   = mk(0,0,0,0,0,0,2'b00,1,2'b00,2'b10,0,0,0,0,0);
    localparam logic [17:0] E_RWB     = mk(0,0,0,0,0,0,2'b00,0,2'b00,2'b00,1,1,0,0,0);
    localparam logic [17:0] E_IMMWB   = mk(0,0,0,0,0,0,2'b00,0,2'b00,2'b00,1,0,0,0,0);
    localparam logic [17:0] E_BRANCH  = mk(0,0,0,0,0,1,2'b01,1,2'b00,2'b01,0,0,0,0,0);
    localparam logic [17:0] E_JUMP    = mk(0,0,0,0,1,0,2'b10,0,2'b00,2'b00,0,0,0,0,0);
    localparam logic [17:0] E_HALT    = mk(0,0,0,0,0,0,2'b00,0,2'b00,2'b00,0,0,0,1,0);
    localparam logic [17:0] E_TRAP    = mk(0,0,0,0,0,0,2'b00,0,2'b00,2'b00,0,0,0,0,1);

    logic [17:0] exp_q[$];
    string       tag_q[$];
    int          total;
    int          bad;

    function automatic logic [17:0] observed();
        return {bus.mem_req, bus.mem_we, bus.iord, bus.ir_write, bus.pc_write,
                bus.pc_write_cond, bus.pc_src, bus.alu_src_a, bus.alu_src_b,
                bus.aoi, bus.reg_write, bus.reg_dst, bus.mem_to_reg,
                bus.halted, bus.illegal};
    endfunction

    // Pop the oldest expectation and compare it with the live outputs
    task automatic check_now();
        logic [17:0] e;
        logic [17:0] o;
        string       t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        o = observed();
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%05h expected=%05h", t, o, e);
        end
    endtask

    // One clock cycle: drive mem_ready, queue expectation, check mid-cycle,
    // then advance to just after the next rising edge.
    task automatic step(input logic rdy, input logic [17:0] e, input string t);
        bus.mem_ready = rdy;
        exp_q.push_back(e);
        tag_q.push_back(t);
        @(negedge clk);
        check_now();
        @(posedge clk);
        #1;
    endtask

    // Assert reset between edges and check outputs clear without a clock
    task automatic async_reset(input string t);
        #2;
        rst_n = 1'b0;
        exp_q.push_back(E_IDLE);
        tag_q.push_back(t);
        #1;
        check_now();
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.opcode    = 4'b0000;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b0;

        // Reset state, even with a stray ready
        @(posedge clk);
        #1;
        bus.mem_ready = 1'b1;
        @(negedge clk);
        exp_q.push_back(E_IDLE);
        tag_q.push_back("reset_idle");
        check_now();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b1, E_IDLE, "idle_no_start");

        // Reset in the middle of a stalled fetch
        bus.start = 1'b1;
        step(1'b0, E_IDLE, "idle_start");
        step(1'b0, E_FETCH_W, "fetch_stall");
        async_reset("reset_mid_fetch");
        step(1'b0, E_IDLE, "post_reset_idle0");
        step(1'b1, E_IDLE, "post_reset_idle1");

        // R-type, zero-wait
        bus.start  = 1'b1;
        bus.opcode = 4'b0000;
        step(1'b1, E_IDLE, "r_idle");
        bus.start = 1'b0;
        step(1'b1, E_FETCH_R, "r_fetch");
        step(1'b1, E_DECODE, "r_decode");
        step(1'b1, E_REXEC, "r_exec");
        step(1'b1, E_RWB, "r_wb");

        // LW with two wait cycles on each access
        bus.opcode = 4'b0001;
        bus.start  = 1'b1;
        step(1'b0, E_FETCH_W, "lw_fetch_w0");
        step(1'b0, E_FETCH_W, "lw_fetch_w1");
        step(1'b1, E_FETCH_R, "lw_fetch_r");
        step(1'b1, E_DECODE, "lw_decode");
        step(1'b1, E_ADDR, "lw_addr");
        step(1'b0, E_MREAD, "lw_read_w0");
        step(1'b0, E_MREAD, "lw_read_w1");
        step(1'b1, E_MREAD, "lw_read_r");
        step(1'b1, E_MWB, "lw_wb");
        bus.start = 1'b0;

        // BEQ with zero set
        bus.opcode = 4'b0011;
        bus.zero   = 1'b1;
        step(1'b1, E_FETCH_R, "beq_fetch");
        step(1'b1, E_DECODE, "beq_decode");
        step(1'b1, E_BRANCH, "beq_branch");
        bus.zero = 1'b0;

        // SW with one write wait cycle
        bus.opcode = 4'b0010;
        step(1'b1, E_FETCH_R, "sw_fetch");
        step(1'b1, E_DECODE, "sw_decode");
        step(1'b1, E_ADDR, "sw_addr");
        step(1'b0, E_MWRITE, "sw_write_w");
        step(1'b1, E_MWRITE, "sw_write_r");

        // ADDI
        bus.opcode = 4'b0100;
        step(1'b1, E_FETCH_R, "addi_fetch");
        step(1'b1, E_DECODE, "addi_decode");
        step(1'b1, E_ADDR, "addi_exec");
        step(1'b1, E_IMMWB, "addi_wb");

        // J
        bus.opcode = 4'b0101;
        step(1'b1, E_FETCH_R, "j_fetch");
        step(1'b1, E_DECODE, "j_decode");
        step(1'b1, E_JUMP, "j_jump");

        // Illegal opcode 1000
        bus.opcode = 4'b1000;
        step(1'b1, E_FETCH_R, "ill_fetch");
        step(1'b1, E_DECODE, "ill_decode");
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
        for (int i = 0; i < 6; i++) begin
            bus.start = i[0];
            step(1'b1, E_TRAP, "ill_trap_hold");
        end
        async_reset("ill_trap_reset");
        step(1'b1, E_IDLE, "ill_post_reset");
        bus.start = 1'b1;
        step(1'b1, E_IDLE, "ill_restart");
        bus.start = 1'b0;
`else
        step(1'b0, E_FETCH_W, "ill_nop_refetch");
`endif

        // HALT held with start toggling, cleared only by reset
        bus.opcode = 4'b1111;
        step(1'b1, E_FETCH_R, "halt_fetch");
        step(1'b1, E_DECODE, "halt_decode");
        for (int i = 0; i < 22; i++) begin
            bus.start = i[0];
            step(1'b1, E_HALT, "halt_hold");
        end
        async_reset("halt_reset");
        step(1'b1, E_IDLE, "halt_post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
